// File: rtl/kernel_fetch_ctrl_pkg.sv
// Shared types and helpers for the kernel fetch sequencer.
package kfetch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} kfetch_state_t;

  localparam int DEF_KERNEL_NUM = 1024;

  // Kernel index width; a single-entry RAM still needs a 1-bit address.
  function automatic int kaddr_w(input int kernel_num);
    return (kernel_num > 1) ? $clog2(kernel_num) : 1;
  endfunction

endpackage

// File: rtl/kernel_fetch_ctrl_if.sv
// Kernel beat stream from the fetch sequencer to the PE array.
// Handshake: a beat transfers on a clock edge where kern_valid && kern_ready; once raised, kern_valid,
// kern_data and kern_last hold until that transfer, and kern_ready may change freely.
interface kernel_fetch_ctrl_if #(parameter int DATA_W = 512);
  logic              kern_valid;
  logic              kern_ready;
  logic [DATA_W-1:0] kern_data;
  logic              kern_last;

  modport master (output kern_valid, output kern_data, output kern_last, input kern_ready);
  modport slave  (input kern_valid, input kern_data, input kern_last, output kern_ready);
endinterface

// File: rtl/kernel_fetch_ctrl_fifo.sv
// Small synchronous FIFO; head is visible on dout while not empty.
module kfetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign dout    = mem[rd_ptr];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kernel_fetch_ctrl.sv
// Read sequencer for the banked kernel RAM: issues consecutive kernel addresses and streams the
// returned words to the PE array through a small FIFO so backpressure never drops a kernel.
module kernel_fetch_ctrl
  import kfetch_pkg::*;
#(
  parameter int pWEIGHT_DATA_WIDTH = 64,
  parameter int pULTRA_RAM_NUM     = 8,
  parameter int pKERNEL_NUM        = DEF_KERNEL_NUM,
  parameter int pFIFO_DEPTH        = 4,
  localparam int KADDR_W = kaddr_w(pKERNEL_NUM),
  localparam int DATA_W  = pWEIGHT_DATA_WIDTH * pULTRA_RAM_NUM
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KADDR_W-1:0]  base_idx,
  input  logic [KADDR_W:0]    kernel_cnt,
  input  logic                load_busy,
  output logic [KADDR_W-1:0]  kernel_addr,
  input  logic [DATA_W-1:0]   kernel_data,
  output logic                busy,
  output logic                done,
  output kfetch_state_t       fsm_state,
  kernel_fetch_ctrl_if.master kern
);

  localparam int FCW = $clog2(pFIFO_DEPTH + 1);

  kfetch_state_t     state, state_nxt;
  logic [KADDR_W:0]  issued_cnt;
  logic [KADDR_W:0]  cnt_q;
  logic              rd_vld;
  logic              rd_last;
  logic              issue;
  logic              pop;
  logic              drained;
  logic [FCW-1:0]    fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [DATA_W:0]   fifo_dout;

  // Slots are reserved for reads in flight; a same-cycle pop is deliberately not credited.
  assign issue = (state == RUN) && !load_busy && (issued_cnt < cnt_q) && !fifo_full &&
                 ((32'(fifo_count) + 32'(rd_vld)) < 32'(pFIFO_DEPTH));
  assign pop     = kern.kern_valid && kern.kern_ready;
  assign drained = !rd_vld && (fifo_empty || ((fifo_count == FCW'(1)) && pop));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (kernel_cnt == '0) ? DONE : RUN;
      RUN:     if (issued_cnt == cnt_q) state_nxt = DRAIN;
      DRAIN:   if (drained) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kernel_addr <= '0;
      issued_cnt  <= '0;
      cnt_q       <= '0;
      rd_vld      <= 1'b0;
      rd_last     <= 1'b0;
    end else begin
      rd_vld  <= issue;
      rd_last <= issue && (issued_cnt == cnt_q - 1'b1);
      if (state == IDLE && start) begin
        kernel_addr <= base_idx;
        issued_cnt  <= '0;
        cnt_q       <= kernel_cnt;
      end else if (issue) begin
        kernel_addr <= (kernel_addr == KADDR_W'(pKERNEL_NUM - 1)) ? '0 : kernel_addr + 1'b1;
        issued_cnt  <= issued_cnt + 1'b1;
      end
    end
  end

  kfetch_fifo #(.WIDTH(DATA_W + 1), .DEPTH(pFIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_vld),
    .din   ({rd_last, kernel_data}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign kern.kern_valid = !fifo_empty;
  assign kern.kern_data  = fifo_dout[DATA_W-1:0];
  assign kern.kern_last  = !fifo_empty && fifo_dout[DATA_W];
  assign busy            = (state != IDLE);
  assign done            = (state == DONE);
  assign fsm_state       = state;

endmodule

// File: tb/tb_kernel_fetch_ctrl.sv
// Bench for kernel_fetch_ctrl: directed jobs plus random jobs under random backpressure/load_busy.
module tb_kernel_fetch_ctrl;
  import kfetch_pkg::*;

  localparam int DW      = 64;
  localparam int NUM     = 8;
  localparam int KNUM    = 1024;
  localparam int DEPTH   = 4;
  localparam int KADDR_W = 10;
  localparam int DATA_W  = DW * NUM;
  localparam int CW      = DATA_W + 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [KADDR_W-1:0]  base_idx;
  logic [KADDR_W:0]    kernel_cnt;
  logic                load_busy;
  logic [KADDR_W-1:0]  kernel_addr;
  logic [DATA_W-1:0]   kernel_data;
  logic                busy;
  logic                done;
  kfetch_state_t       fsm_state;
  logic                ready;

  kernel_fetch_ctrl_if #(.DATA_W(DATA_W)) kif ();
  assign kif.kern_ready = ready;

  kernel_fetch_ctrl #(
    .pWEIGHT_DATA_WIDTH(DW), .pULTRA_RAM_NUM(NUM), .pKERNEL_NUM(KNUM), .pFIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_idx(base_idx), .kernel_cnt(kernel_cnt),
    .load_busy(load_busy), .kernel_addr(kernel_addr), .kernel_data(kernel_data),
    .busy(busy), .done(done), .fsm_state(fsm_state), .kern(kif)
  );

  // ---------------- clock / RAM model ----------------
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] ram_word(input int idx);
    logic [DATA_W-1:0] w;
    for (int b = 0; b < NUM; b++)
      w[b*DW +: DW] = {32'(idx + 1) * 32'h9E3779B1, 16'(b), 16'(idx)};
    return w;
  endfunction

  // Registered RAM output; a write cycle (load_busy) skips the read.
  always @(posedge clk) if (!load_busy) kernel_data <= ram_word(int'(kernel_addr));

  // ---------------- scoreboard state ----------------
  logic [CW-1:0] exp_q[$];
  int n_total = 0, n_bad = 0;
  int cyc = 0, hs_cnt = 0, last_hs_cyc = -1, rise_cyc = -1, done_cnt = 0, done_cyc = -1;
  bit rnd_ready = 0, rnd_lb = 0;
  bit prev_valid = 0, prev_stall = 0, prev_lb_run = 0;
  logic [CW-1:0] prev_beat;
  logic [KADDR_W-1:0] prev_addr;
  int job_c0, job_d0, job_hs0, job_cnt;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: observe the cycle at the falling edge, then advance and apply random drive.
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      prev_valid = 0; prev_stall = 0; prev_lb_run = 0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", CW'(kif.kern_valid), CW'(1));
        check("stall_data", {kif.kern_last, kif.kern_data}, prev_beat);
      end
      if (prev_lb_run) check("lb_hold", CW'(kernel_addr), CW'(prev_addr));
      if (!kif.kern_valid) check("last_gate", CW'(kif.kern_last), CW'(0));
      if (dut.u_fifo.push) check("push_full", CW'(dut.u_fifo.full), CW'(0));
      if (kif.kern_valid && !prev_valid) rise_cyc = cyc;
      if (kif.kern_valid && ready) begin
        if (exp_q.size() == 0) check("extra_beat", CW'(1), CW'(0));
        else check("beat", {kif.kern_last, kif.kern_data}, exp_q.pop_front());
        hs_cnt++;
        last_hs_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      prev_valid  = kif.kern_valid;
      prev_stall  = kif.kern_valid && !ready;
      prev_beat   = {kif.kern_last, kif.kern_data};
      prev_lb_run = load_busy && (fsm_state == RUN);
      prev_addr   = kernel_addr;
    end
    @(posedge clk);
    cyc++;
    #1;
    if (rnd_ready) ready = ($urandom_range(0, 3) != 0);
    if (rnd_lb)    load_busy = ($urandom_range(0, 4) == 0);
  endtask

  // Reference: a job yields beats for indices base..base+cnt-1 modulo KNUM, last flag on the final one.
  task automatic start_job(input int base, input int cnt);
    base_idx   = KADDR_W'(base);
    kernel_cnt = (KADDR_W + 1)'(cnt);
    start      = 1'b1;
    job_c0 = cyc; job_d0 = done_cnt; job_hs0 = hs_cnt; job_cnt = cnt;
    for (int i = 0; i < cnt; i++)
      exp_q.push_back({1'(i == cnt - 1), ram_word((base + i) % KNUM)});
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == job_d0 && n < 600) begin tick(); n++; end
    check("done_seen", CW'(done_cnt != job_d0), CW'(1));
    if (job_cnt == 0) check("done_cyc_empty", CW'(done_cyc), CW'(job_c0 + 1));
    else              check("done_after_last", CW'(done_cyc), CW'(last_hs_cyc + 1));
    check("beat_count", CW'(hs_cnt - job_hs0), CW'(job_cnt));
    check("exp_drained", CW'(exp_q.size()), CW'(0));
    tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_idx = '0; kernel_cnt = '0; load_busy = 1'b0; ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_state", CW'(fsm_state), CW'(IDLE));
    check("rst_valid", CW'(kif.kern_valid), CW'(0));
    check("rst_last", CW'(kif.kern_last), CW'(0));
    check("rst_busy", CW'(busy), CW'(0));
    check("rst_done", CW'(done), CW'(0));
    check("rst_addr", CW'(kernel_addr), CW'(0));
    tick();

    // Basic job: beats at cycles 3..6 on consecutive cycles, done right after.
    start_job(5, 4);
    wait_done();
    check("first_valid_cyc", CW'(rise_cyc), CW'(job_c0 + 3));
    check("last_beat_cyc", CW'(last_hs_cyc), CW'(job_c0 + 6));

    // Address wrap 1022, 1023, 0.
    start_job(1022, 3);
    wait_done();

    // Backpressure: fetch stops at FIFO depth.
    ready = 1'b0;
    start_job(10, 8);
    repeat (10) tick();
    check("stall_fill", CW'(dut.u_fifo.count), CW'(DEPTH));
    check("stall_addr", CW'(kernel_addr), CW'(10 + DEPTH));
    ready = 1'b1;
    wait_done();

    // load_busy in cycles 2..4 of a 6-kernel job.
    start_job(40, 6);
    tick();
    load_busy = 1'b1;
    repeat (3) tick();
    load_busy = 1'b0;
    wait_done();

    // Empty job, then a second start while busy is ignored.
    start_job(77, 0);
    wait_done();
    start_job(100, 3);
    tick();
    base_idx = 10'd200; kernel_cnt = 11'd5; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    repeat (5) tick();
    check("ignored_start", CW'(hs_cnt - job_hs0), CW'(3));

    // Reset with two entries in the FIFO.
    ready = 1'b0;
    start_job(300, 8);
    repeat (3) tick();
    check("pre_rst_count", CW'(dut.u_fifo.count), CW'(2));
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    check("post_rst_valid", CW'(kif.kern_valid), CW'(0));
    check("post_rst_busy", CW'(busy), CW'(0));
    ready = 1'b1;
    tick();
    start_job(500, 5);
    wait_done();

    // Random jobs under random backpressure and load_busy.
    rnd_ready = 1; rnd_lb = 1;
    for (int j = 0; j < 16; j++) begin
      start_job($urandom_range(0, KNUM - 1), $urandom_range(0, 12));
      wait_done();
    end
    rnd_ready = 0; rnd_lb = 0; ready = 1'b1; load_busy = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
